mmio_uart_tx: RTL and testbench

- Memory-mapped UART transmitter downstream of the single-cycle CPU's data-memory path.
- The top-level address decode asserts `sel` for stores and loads in the peripheral window. The block buffers bytes in a small FIFO and serializes them onto `tx` as 8N1 frames.
- Software polls STATUS. The CPU never stalls: stores to a full FIFO are dropped and flagged.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 44 ++++
 rtl/mmio_uart_tx.sv | 160 ++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared register offsets, STATUS bit positions and FSM states for mmio_uart_tx
package uart_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int STAT_FULL     = 0;
  localparam int STAT_EMPTY    = 1;
  localparam int STAT_BUSY     = 2;
  localparam int STAT_OVERFLOW = 3;
  localparam int STAT_ODD      = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } txState_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with extra-MSB pointers, asynchronous active-high reset
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] popData,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;

  assign full    = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign empty   = (wrPtr == rdPtr);
  assign popData = mem[rdPtr[AW-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push && !full)
        wrPtr <= wrPtr + 1'b1;
      if (pop && !empty)
        rdPtr <= rdPtr + 1'b1;
    end
  end

  // Storage needs no reset: pointers alone define what is valid.
  always_ff @(posedge clock) begin
    if (push && !full)
      mem[wrPtr[AW-1:0]] <= pushData;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with byte FIFO and STATUS polling
// Optional parity stage (even by default, odd via CTRL bit1) is built when UART_TX_PARITY_EN is defined.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sel,
  input  logic        memWrite,
  input  logic        memRead,
  input  logic [3:0]  address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        tx,
  output logic        irq
);

  localparam int BAUD_W = $clog2(CLK_DIV);

  txState_t          state;
  txState_t          stateNext;
  logic [BAUD_W-1:0] baudCnt;
  logic [2:0]        bitIdx;
  logic [7:0]        shiftReg;
  logic              overflow;
  logic              oddParity;
  logic              txNext;
  logic              pop;
  logic              full;
  logic              empty;
  logic [7:0]        popData;
  logic              baudLast;
  logic              busy;
  logic              txDataWr;
  logic              ctrlWr;
  logic              push;
  logic              unusedBits;

  assign txDataWr   = sel && memWrite && (address[3:2] == REG_TXDATA);
  assign ctrlWr     = sel && memWrite && (address[3:2] == REG_CTRL);
  assign push       = txDataWr && !full;
  assign baudLast   = (baudCnt == BAUD_W'(CLK_DIV - 1));
  assign busy       = (state != IDLE);
  assign unusedBits = ^{writeData[31:8], writeData[1], address[1:0]};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) txFifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .pushData (writeData[7:0]),
    .pop      (pop),
    .popData  (popData),
    .full     (full),
    .empty    (empty)
  );

  // A dropped store outranks a same-cycle clear so no loss goes unreported.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      overflow <= 1'b0;
    else if (txDataWr && full)
      overflow <= 1'b1;
    else if (ctrlWr && writeData[0])
      overflow <= 1'b0;
  end

`ifdef UART_TX_PARITY_EN
  logic parityBit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      oddParity <= 1'b0;
      parityBit <= 1'b0;
    end else begin
      if (ctrlWr)
        oddParity <= writeData[1];
      if (pop)
        parityBit <= (^popData) ^ oddParity;
    end
  end
`else
  assign oddParity = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:   if (!empty) stateNext = START;
      START:  if (baudLast) stateNext = DATA;
`ifdef UART_TX_PARITY_EN
      DATA:   if (baudLast && bitIdx == 3'd7) stateNext = PARITY;
      PARITY: if (baudLast) stateNext = STOP;
`else
      DATA:   if (baudLast && bitIdx == 3'd7) stateNext = STOP;
`endif
      STOP:   if (baudLast) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    pop    = (state == IDLE) && !empty;
    txNext = 1'b1;
    case (state)
      START:  txNext = 1'b0;
      DATA:   txNext = shiftReg[0];
`ifdef UART_TX_PARITY_EN
      PARITY: txNext = parityBit;
`endif
      default: txNext = 1'b1;
    endcase
  end

  // tx and irq are registered from the current state, hence one clock behind it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx       <= 1'b1;
      irq      <= 1'b1;
      baudCnt  <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
    end else begin
      tx  <= txNext;
      irq <= empty && (state == IDLE);
      if (pop) begin
        shiftReg <= popData;
        baudCnt  <= '0;
        bitIdx   <= '0;
      end else if (state != IDLE) begin
        baudCnt <= baudLast ? '0 : baudCnt + 1'b1;
        if (state == DATA && baudLast) begin
          shiftReg <= {1'b0, shiftReg[7:1]};
          bitIdx   <= bitIdx + 1'b1;
        end
      end
    end
  end

  always_comb begin
    readData = '0;
    if (sel && memRead && address[3:2] == REG_STATUS) begin
      readData[STAT_FULL]     = full;
      readData[STAT_EMPTY]    = empty;
      readData[STAT_BUSY]     = busy;
      readData[STAT_OVERFLOW] = overflow;
      readData[STAT_ODD]      = oddParity;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - randomized self-checking bench for mmio_uart_tx against a frame-level reference model
module tb_mmio_uart_tx;

  localparam int D     = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        memWrite = 1'b0;
  logic        memRead = 1'b0;
  logic [3:0]  address = 4'd0;
  logic [31:0] writeData = 32'd0;
  logic [31:0] readData;
  logic        tx;
  logic        irq;

  mmio_uart_tx #(.CLK_DIV(D), .FIFO_DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .sel       (sel),
    .memWrite  (memWrite),
    .memRead   (memRead),
    .address   (address),
    .writeData (writeData),
    .readData  (readData),
    .tx        (tx),
    .irq       (irq)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: FIFO contents as a queue; transmitter busy until nextFree.
  int         cyc = 0;
  int         nextFree = 0;
  bit         mOvf = 0;
  bit         mOdd = 0;
  bit         irqExp = 1;
  logic [7:0] fifoQ[$];
  logic [7:0] txQ[$];
  int         startQ[$];
  bit         parQ[$];

  always @(posedge clock or posedge reset) begin : model
    bit         popNow;
    bit         wrTx;
    bit         fullPre;
    logic [7:0] b;
    if (reset) begin
      nextFree = 0;
      mOvf     = 0;
      mOdd     = 0;
      irqExp   = 1;
      fifoQ.delete();
      txQ.delete();
      startQ.delete();
      parQ.delete();
    end else begin
      cyc++;
      popNow  = (fifoQ.size() > 0) && (cyc >= nextFree);
      wrTx    = sel && memWrite && (address[3:2] == 2'd0);
      fullPre = (fifoQ.size() == DEPTH);
      irqExp  = (fifoQ.size() == 0) && (cyc >= nextFree);
      if (popNow) begin
        b = fifoQ.pop_front();
        txQ.push_back(b);
        startQ.push_back(cyc + 1);
        parQ.push_back((^b) ^ mOdd);
        nextFree = cyc + FB * D + 1;
      end
      if (wrTx) begin
        if (fullPre) mOvf = 1;
        else fifoQ.push_back(writeData[7:0]);
      end else if (sel && memWrite && address[3:2] == 2'd2) begin
        if (writeData[0]) mOvf = 0;
`ifdef UART_TX_PARITY_EN
        mOdd = writeData[1];
`endif
      end
    end
  end

  function automatic logic [31:0] expStatus();
    logic [31:0] s;
    s    = '0;
    s[0] = (fifoQ.size() == DEPTH);
    s[1] = (fifoQ.size() == 0);
    s[2] = (cyc + 1 < nextFree);
    s[3] = mOvf;
`ifdef UART_TX_PARITY_EN
    s[4] = mOdd;
`endif
    return s;
  endfunction

  // Line monitor: decodes frames at mid-bit and checks them against the model.
  bit          monActive = 0;
  bit          prevTx = 1;
  int          monPhase = 0;
  int          lastStart = 0;
  logic [7:0]  lastByte = 0;
  bit          lastPar = 0;
  logic [FB-1:0] bits;

  always @(negedge clock) begin
    if (reset) begin
      monActive = 0;
    end else begin
      if (!monActive && prevTx && !tx) begin
        monActive = 1;
        monPhase  = 0;
        lastStart = cyc;
        if (startQ.size() == 0) checkVal("unexpectedFrame", 32'd1, 32'd0);
        else checkVal("frameStart", cyc, startQ[0]);
      end else if (monActive) begin
        monPhase++;
      end
      if (monActive && (monPhase % D) == D / 2) begin
        bits[monPhase / D] = tx;
        if (monPhase / D == FB - 1) begin
          monActive = 0;
          lastByte  = bits[8:1];
          checkVal("startBit", {31'd0, bits[0]}, 32'd0);
          checkVal("stopBit", {31'd0, bits[FB-1]}, 32'd1);
          if (txQ.size() > 0) begin
            checkVal("dataByte", {24'd0, bits[8:1]}, {24'd0, txQ[0]});
`ifdef UART_TX_PARITY_EN
            lastPar = bits[9];
            checkVal("parityBit", {31'd0, bits[9]}, {31'd0, parQ[0]});
`endif
            void'(txQ.pop_front());
            void'(startQ.pop_front());
            void'(parQ.pop_front());
          end
        end
      end
      checkVal("irq", {31'd0, irq}, {31'd0, irqExp});
    end
    prevTx = tx;
  end

  task automatic busWrite(input logic [3:0] a, input logic [31:0] d);
    sel = 1; memWrite = 1; address = a; writeData = d;
    @(negedge clock);
    sel = 0; memWrite = 0;
  endtask

  task automatic readReg(input logic [3:0] a, output logic [31:0] v);
    sel = 1; memRead = 1; address = a;
    #1 v = readData;
    @(negedge clock);
    sel = 0; memRead = 0;
  endtask

  task automatic checkStatus(input string tag);
    sel = 1; memRead = 1; address = 4'h4;
    #1 checkVal(tag, readData, expStatus());
    @(negedge clock);
    sel = 0; memRead = 0;
  endtask

  task automatic waitIdle();
    bit done;
    done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clock);
      #1;
      if (fifoQ.size() == 0 && cyc + 1 >= nextFree && !monActive) done = 1;
    end
    if (!done) checkVal("idleTimeout", 32'd0, 32'd1);
    repeat (2) @(negedge clock);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    int          storeCyc;
    bit          hit;
    int          r;

    repeat (3) @(negedge clock);
    #1 checkVal("rstTx", {31'd0, tx}, 32'd1);
    checkVal("rstIrq", {31'd0, irq}, 32'd1);
    #1 reset = 0;
    @(negedge clock);
    readReg(4'h4, v);
    checkVal("rstStatus", v, 32'h2);

    // Single frame: latency, busy flag, decoded byte.
    storeCyc = cyc + 1;
    busWrite(4'h0, 32'h55);
    repeat (6) @(negedge clock);
    readReg(4'h4, v);
    checkVal("busyDuringFrame", {31'd0, v[2]}, 32'd1);
    waitIdle();
    checkVal("firstLatency", lastStart - storeCyc, 32'd2);
    checkVal("byte55", {24'd0, lastByte}, 32'h55);

    // Back-to-back frames.
    busWrite(4'h0, 32'hA1);
    busWrite(4'h0, 32'hA2);
    busWrite(4'h0, 32'hA3);
    checkStatus("statusDuringA");
    waitIdle();
    readReg(4'h4, v);
    checkVal("statusAfterA", v, 32'h2);
    checkVal("lastA3", {24'd0, lastByte}, 32'hA3);

    // Overflow: six stores, five accepted.
    for (int i = 0; i < 6; i++) busWrite(4'h0, 32'h30 + i);
    readReg(4'h4, v);
    checkVal("ovfSet", {31'd0, v[3]}, 32'd1);
    checkVal("fullAfterBurst", {31'd0, v[0]}, 32'd1);
    busWrite(4'h8, 32'h1);
    readReg(4'h4, v);
    checkVal("ovfCleared", {31'd0, v[3]}, 32'd0);
    waitIdle();
    checkVal("lastBurst", {24'd0, lastByte}, 32'h34);

    // Asynchronous reset mid-frame.
    busWrite(4'h0, 32'hC3);
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clock);
      #1;
      if (monActive && monPhase == 15) hit = 1;
    end
    if (!hit) checkVal("midFrameTimeout", 32'd0, 32'd1);
    checkVal("txLowBeforeReset", {31'd0, tx}, 32'd0);
    #1 reset = 1;
    #1 checkVal("asyncTx", {31'd0, tx}, 32'd1);
    @(negedge clock);
    #2 reset = 0;
    @(negedge clock);
    readReg(4'h4, v);
    checkVal("statusAfterReset", v, 32'h2);
    repeat (60) @(negedge clock);

    // Decode corner cases.
    readReg(4'hC, v);
    checkVal("reservedRead", v, 32'd0);
    readReg(4'h0, v);
    checkVal("txdataRead", v, 32'd0);
    readReg(4'h8, v);
    checkVal("ctrlRead", v, 32'd0);
    memRead = 1; address = 4'h4;
    #1 checkVal("noSelRead", readData, 32'd0);
    @(negedge clock);
    memRead = 0;
    sel = 0; memWrite = 1; address = 4'h0; writeData = 32'h99;
    @(negedge clock);
    memWrite = 0;
    busWrite(4'h4, 32'hFF);
    busWrite(4'hC, 32'hFF);
    readReg(4'h4, v);
    checkVal("statusAfterBadStores", v, 32'h2);
    repeat (60) @(negedge clock);

`ifdef UART_TX_PARITY_EN
    busWrite(4'h8, 32'h0);
    busWrite(4'h0, 32'h07);
    waitIdle();
    checkVal("parityEven07", {31'd0, lastPar}, 32'd1);
    busWrite(4'h8, 32'h2);
    readReg(4'h4, v);
    checkVal("oddStatusBit", {31'd0, v[4]}, 32'd1);
    busWrite(4'h0, 32'h07);
    waitIdle();
    checkVal("parityOdd07", {31'd0, lastPar}, 32'd0);
    busWrite(4'h8, 32'h0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 30) busWrite(4'h0, $urandom);
      else if (r < 42) checkStatus("randStatus");
      else if (r < 46) busWrite(4'h8, $urandom_range(0, 3));
      else if (r < 49) busWrite(4'hC, $urandom);
      else if (r < 51) busWrite(4'h4, $urandom);
      else @(negedge clock);
    end
    waitIdle();
    checkStatus("finalStatus");
    checkVal("queuesDrained", txQ.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
